uart_hex_printer: RTL and testbench
===================================

Name: uart_hex_printer

Overview:
- Parametrised print engine that turns a DATA_WIDTH-bit value into an ASCII hex string and streams it, one character at a time, into a uart_tx-style transmitter (tx_start / tx_data / tx_busy).
- Generalises the fixed 8-digit counter printout to any width, with upper/lower case, leading-zero suppression and an optional CR LF terminator.
- Sits between application logic (valid/ready request) and uart_tx.

Parameters:
- DATA_WIDTH, 32: width of printed value, 4..64; DIGITS = (DATA_WIDTH+3)/4, top nibble zero-padded.
- NEWLINE, 1: 1 = append 8'h0d, 8'h0a after the digits; 0 = no terminator.
- UPPERCASE, 1: 1 = digits A-F as 8'h41..8'h46; 0 = a-f as 8'h61..8'h66.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  print request
- req_ready  output  1  engine idle, request accepted when req_valid && req_ready
- req_data  input  DATA_WIDTH  value to print, sampled on accept
- req_zsup  input  1  leading-zero suppression for this request, sampled on accept
- tx_start  output  1  character strobe to uart_tx
- tx_data  output  8  character to transmit
- tx_busy  input  1  uart_tx busy flag
- busy  output  1  high from accept until the last character completes
- done  output  1  one-cycle pulse when a string finishes

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready=1 is the only output set high; tx_start=0, tx_data=8'h00, busy=0, done=0; internal counters cleared. Reset mid-string aborts immediately, with no partial completion and no done.
- States: IDLE, LOAD, SEND, ACK, DRAIN, FIN.
- IDLE: req_ready=1. On accept, latch req_data (zero-extended to DIGITS*4 bits) and req_zsup, go to LOAD. req_ready=0 in all other states.
- LOAD (1 cycle): build character count. With zsup, skip leading zero nibbles, but always print at least one digit (value 0 prints "0"). Go to SEND.
- SEND: drive tx_data = current character, tx_start=1, go to ACK.
- ACK: hold tx_start=1 and tx_data stable until tx_busy=1 is sampled, then tx_start=0 and go to DRAIN. No timeout; tx_start is held indefinitely.
- DRAIN: wait for tx_busy=0. If more characters remain, advance the index and go to SEND; else go to FIN.
- FIN: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE. A new request can be accepted on the cycle after FIN.
- Character order: [prefix, if enabled] then digits MSB nibble first, then [CR, LF] if NEWLINE=1.
- Nibble to ASCII mapping: 0-9 to 8'h30-8'h39; 10-15 per UPPERCASE.
- Minimum character-to-character gap: SEND, ACK, DRAIN = 3 cycles plus uart_tx frame time.
- tx_busy already high on entry to SEND (previous frame tail): ACK exits on it. This is legal because uart_tx latches on start. Engine relies on uart_tx asserting busy the cycle after start.
- busy = (state != IDLE).
- req_data changes after accept have no effect.

Optional Feature:
- Macro UART_HEX_PREFIX_EN.
- Defined: every string is preceded by "0x" (8'h30, 8'h78), regardless of UPPERCASE and zsup. Character count grows by 2.
- Undefined: no prefix logic is synthesised; the string starts with the first digit.

Test Plan:
- DATA_WIDTH=32, UPPERCASE=1, NEWLINE=1, zsup=0, data 32'h0000BEEF -> tx bytes "0000BEEF",0d,0a (10 chars); one done pulse; req_ready low throughout.
- Same config, zsup=1, data 32'h0000BEEF -> "BEEF",0d,0a. Data 32'h0 -> "0",0d,0a.
- DATA_WIDTH=10, UPPERCASE=0, NEWLINE=0, data 10'h3A5 -> "3a5". Top digit padded correctly, no terminator.
- Behavioural uart_tx model with busy delays of 1 and 5 cycles -> tx_start drops the cycle after busy is sampled high; each byte is seen exactly once; tx_data is stable while tx_start is high.
- Assert rst_n=0 during the third character -> tx_start, busy, done go 0 asynchronously; after release, req_ready=1 and a fresh request for 32'h12345678 prints correctly.
- UART_HEX_PREFIX_EN defined, data 32'hFF, zsup=1 -> "0xFF",0d,0a.

Source files
------------

// File: rtl/uart_hex_printer.sv
// uart_hex_printer: converts a DATA_WIDTH-bit value into an ASCII hex string
// and streams it one character at a time into a uart_tx-style transmitter.
// Optional "0x" prefix is compiled in when UART_HEX_PREFIX_EN is defined.
module uart_hex_printer #(
   parameter int DATA_WIDTH = 32,
   parameter int NEWLINE    = 1,
   parameter int UPPERCASE  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_data,
   input  logic                  req_zsup,
   output logic                  tx_start,
   output logic [7:0]            tx_data,
   input  logic                  tx_busy,
   output logic                  busy,
   output logic                  done
);

   localparam int DIGITS = (DATA_WIDTH + 3) / 4;
   localparam int XW     = DIGITS * 4;
   localparam int CW     = 6;
   localparam int NLC    = (NEWLINE != 0) ? 2 : 0;
`ifdef UART_HEX_PREFIX_EN
   localparam int PFX    = 2;
`else
   localparam int PFX    = 0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SEND, S_ACK, S_DRAIN, S_FIN
   } state_t;

   state_t          r_state, w_next;
   logic [XW-1:0]   r_data, w_data_ext;
   logic            r_zsup;
   logic [CW-1:0]   r_ndig, r_idx, w_sig, w_total;
   logic [7:0]      w_char;
   logic            w_accept, w_last;
   int              w_pos, w_nibpos;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10)
         return 8'h30 + {4'h0, n};
      else if (UPPERCASE != 0)
         return 8'h41 + {4'h0, n} - 8'd10;
      else
         return 8'h61 + {4'h0, n} - 8'd10;
   endfunction

   assign w_accept = req_valid && (r_state == S_IDLE);
   assign w_total  = CW'(PFX) + r_ndig + CW'(NLC);
   assign w_last   = (r_idx == (w_total - CW'(1)));

   // Zero-extend the request so the top nibble is padded for odd widths
   always_comb begin
      w_data_ext = '0;
      w_data_ext[DATA_WIDTH-1:0] = req_data;
   end

   // Number of significant digits (highest non-zero nibble), at least one
   always_comb begin
      w_sig = CW'(1);
      for (int i = 0; i < DIGITS; i++) begin
         if (r_data[i*4 +: 4] != 4'h0)
            w_sig = CW'(i + 1);
      end
   end

   // Character at the current index: [prefix] digits MSB-first [CR LF]
   always_comb begin
      w_char   = 8'h00;
      w_nibpos = 0;
      w_pos    = int'(r_idx) - PFX;
`ifdef UART_HEX_PREFIX_EN
      if (r_idx == CW'(0))
         w_char = 8'h30;
      else if (r_idx == CW'(1))
         w_char = 8'h78;
      else
`endif
      if (w_pos < int'(r_ndig)) begin
         w_nibpos = int'(r_ndig) - 1 - w_pos;
         w_char   = hex_ascii(4'(r_data >> (4 * w_nibpos)));
      end else if (w_pos == int'(r_ndig))
         w_char = 8'h0d;
      else
         w_char = 8'h0a;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Latched request, digit count and character index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_zsup <= 1'b0;
         r_ndig <= '0;
         r_idx  <= '0;
      end else begin
         if (w_accept) begin
            r_data <= w_data_ext;
            r_zsup <= req_zsup;
            r_idx  <= '0;
         end
         if (r_state == S_LOAD)
            r_ndig <= r_zsup ? w_sig : CW'(DIGITS);
         if ((r_state == S_DRAIN) && !tx_busy && !w_last)
            r_idx <= r_idx + CW'(1);
      end
   end

   // Next-state and output decode; tx_start is held in ACK until busy is seen
   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      tx_start  = 1'b0;
      tx_data   = 8'h00;
      busy      = 1'b1;
      done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid)
               w_next = S_LOAD;
         end
         S_LOAD:  w_next = S_SEND;
         S_SEND: begin
            tx_start = 1'b1;
            tx_data  = w_char;
            w_next   = S_ACK;
         end
         S_ACK: begin
            tx_start = 1'b1;
            tx_data  = w_char;
            if (tx_busy)
               w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (!tx_busy)
               w_next = w_last ? S_FIN : S_SEND;
         end
         S_FIN: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_hex_printer.sv
// Bench for uart_hex_printer: two instances (32-bit upper/CRLF and 10-bit
// lower/no terminator) share a behavioural uart_tx model; captured bytes are
// compared to a string built from the value with plain arithmetic.
module tb_uart_hex_printer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_zsup = 1'b0;
   logic [31:0] a_req_data = '0;
   logic [9:0]  b_req_data = '0;

   logic        a_ready, a_start, a_busy, a_done;
   logic [7:0]  a_data;
   logic        b_ready, b_start, b_busy, b_done;
   logic [7:0]  b_data;
   logic        ub = 1'b0;
   int          cnt = 0;
   int          busy_len = 1;

   uart_hex_printer #(.DATA_WIDTH(32), .NEWLINE(1), .UPPERCASE(1)) u_a (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(a_ready),
      .req_data(a_req_data), .req_zsup(req_zsup), .tx_start(a_start),
      .tx_data(a_data), .tx_busy(ub), .busy(a_busy), .done(a_done));

   uart_hex_printer #(.DATA_WIDTH(10), .NEWLINE(0), .UPPERCASE(0)) u_b (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(b_ready),
      .req_data(b_req_data), .req_zsup(req_zsup), .tx_start(b_start),
      .tx_data(b_data), .tx_busy(ub), .busy(b_busy), .done(b_done));

   logic       m_start, m_ready, m_busy, m_done;
   logic [7:0] m_data;
   assign m_start = sel ? b_start : a_start;
   assign m_data  = sel ? b_data  : a_data;
   assign m_ready = sel ? b_ready : a_ready;
   assign m_busy  = sel ? b_busy  : a_busy;
   assign m_done  = sel ? b_done  : a_done;

   int n_chk = 0;
   int n_err = 0;
   int done_cnt = 0;
   logic [7:0] cap_q[$];
   logic [7:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // uart_tx model: latches a byte on start when idle, busy from next cycle
   always @(posedge clk) begin
      if (!rst_n) begin
         ub  <= 1'b0;
         cnt <= 0;
      end else if (ub) begin
         cnt <= cnt - 1;
         if (cnt <= 1) ub <= 1'b0;
      end else if (m_start) begin
         cap_q.push_back(m_data);
         ub  <= 1'b1;
         cnt <= busy_len;
      end
   end

   // Handshake protocol monitor
   logic       last_ok = 1'b0, last_start = 1'b0, last_busy = 1'b0;
   logic [7:0] last_data = '0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_done) done_cnt++;
         if (m_busy) check_eq("ready_low_when_busy", {63'd0, m_ready}, 64'd0);
         if (last_ok && last_start && last_busy)
            check_eq("start_drop_after_busy", {63'd0, m_start}, 64'd0);
         if (last_ok && last_start && m_start)
            check_eq("data_stable", {56'd0, m_data}, {56'd0, last_data});
      end
      last_ok    = rst_n;
      last_start = m_start;
      last_busy  = ub;
      last_data  = m_data;
   end

   // Reference string: [0x] hex digits MSB-first (optionally zero-suppressed) [CR LF]
   task automatic build_exp(input logic [63:0] v, input int w, input bit zs,
                            input bit uc, input bit nl);
      string hx;
      int    nd, first;
      logic [63:0] val;
      hx = uc ? "0123456789ABCDEF" : "0123456789abcdef";
      exp_q.delete();
`ifdef UART_HEX_PREFIX_EN
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h78);
`endif
      val = v;
      if (w < 64) val = val & ((64'd1 << w) - 64'd1);
      nd = (w + 3) / 4;
      first = nd - 1;
      if (zs)
         while (first > 0 && ((val >> (4 * first)) & 64'hF) == 64'd0) first--;
      for (int d = first; d >= 0; d--)
         exp_q.push_back(hx[int'((val >> (4 * d)) & 64'hF)]);
      if (nl) begin
         exp_q.push_back(8'h0d);
         exp_q.push_back(8'h0a);
      end
   endtask

   task automatic start_req(input bit s, input logic [63:0] v, input bit zs);
      if (s) b_req_data = v[9:0];
      else   a_req_data = v[31:0];
      req_zsup  = zs;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      a_req_data = $urandom;
      b_req_data = 10'($urandom);
      req_zsup   = 1'($urandom);
   endtask

   task automatic run(input bit s, input logic [63:0] v, input bit zs,
                      input int blen, input string tag);
      int cyc;
      sel = s;
      busy_len = blen;
      @(negedge clk);
      cap_q.delete();
      done_cnt = 0;
      build_exp(v, s ? 10 : 32, zs, !s, !s);
      check_eq({tag, "_ready_idle"}, {63'd0, m_ready}, 64'd1);
      start_req(s, v, zs);
      cyc = 0;
      while (done_cnt == 0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check_eq({tag, "_timeout"}, {63'd0, (cyc < 3000)}, 64'd1);
      repeat (2) @(negedge clk);
      check_eq({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      check_eq({tag, "_busy_after"}, {63'd0, m_busy}, 64'd0);
      check_eq({tag, "_ready_after"}, {63'd0, m_ready}, 64'd1);
      check_eq({tag, "_nchars"}, 64'(cap_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
         check_eq($sformatf("%s_char%0d", tag, i), {56'd0, cap_q[i]}, {56'd0, exp_q[i]});
   endtask

   initial begin
      int cyc;
      logic [63:0] rv;
      #12;
      check_eq("rst_ready", {63'd0, a_ready}, 64'd1);
      check_eq("rst_start", {63'd0, a_start}, 64'd0);
      check_eq("rst_data", {56'd0, a_data}, 64'd0);
      check_eq("rst_busy", {63'd0, a_busy}, 64'd0);
      check_eq("rst_done", {63'd0, a_done}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run(1'b0, 64'h0000BEEF, 1'b0, 1, "beef");
      run(1'b0, 64'h0000BEEF, 1'b1, 5, "beef_zs");
      run(1'b0, 64'h0,        1'b1, 2, "zero_zs");
      run(1'b1, 64'h3A5,      1'b0, 5, "w10");
      run(1'b1, 64'h005,      1'b1, 1, "w10_zs");
      run(1'b0, 64'hFF,       1'b1, 3, "ff_zs");

      for (int k = 0; k < 8; k++) begin
         rv = {32'($urandom), 32'($urandom)};
         rv = rv >> $urandom_range(0, 63);
         run(1'($urandom), rv, 1'($urandom), int'($urandom_range(1, 5)), $sformatf("rnd%0d", k));
      end

      // Reset while the third character is being offered
      sel = 1'b0;
      busy_len = 3;
      @(negedge clk);
      cap_q.delete();
      done_cnt = 0;
      start_req(1'b0, 64'hCAFEF00D, 1'b0);
      cyc = 0;
      while (!(cap_q.size() == 2 && m_start && !ub) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("midrst_reach_third", {63'd0, (cyc < 3000)}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("midrst_start", {63'd0, a_start}, 64'd0);
      check_eq("midrst_busy", {63'd0, a_busy}, 64'd0);
      check_eq("midrst_done", {63'd0, a_done}, 64'd0);
      check_eq("midrst_ready", {63'd0, a_ready}, 64'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("midrst_no_done", 64'(done_cnt), 64'd0);
      run(1'b0, 64'h12345678, 1'b0, 2, "post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
